fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Shares one single-port frame-buffer SRAM between two requesters: the pixelstream refill path, which reads fixed-length bursts, and the CPU's Avalon-MM slave port, which does single-word reads and writes. The block sits between the Clarvi SoC interconnect and the on-chip frame-buffer memory that feeds the LCD pixelstream. Pixel bursts have priority by default, and a configurable fairness slot bounds CPU latency.

## Interface
Parameters:
- ADDR_W, 16, word address width for the CPU, pixel and memory ports
- DATA_W, 32, data width; must be a multiple of 8
- BURST_LEN, 8, words per pixel burst; range 2..256

Ports:
- clk_clk  in  1  single clock for the whole block
- reset_reset  in  1  reset, synchronous and active-high
- cpu_address  in  ADDR_W  CPU word address
- cpu_read  in  1  CPU read request
- cpu_write  in  1  CPU write request
- cpu_writedata  in  DATA_W  CPU write data
- cpu_byteenable  in  DATA_W/8  CPU byte enables
- cpu_waitrequest  out  1  Avalon waitrequest; the access is accepted in the cycle this is low
- cpu_readdata  out  DATA_W  read data
- cpu_readdatavalid  out  1  read data valid
- pix_req  in  1  request for a burst (level)
- pix_addr  in  ADDR_W  burst base address; sampled when the burst is granted
- pix_ack  out  1  one-cycle pulse marking burst acceptance
- pix_data  out  DATA_W  burst read data
- pix_valid  out  1  pix_data valid
- pix_last  out  1  marks the final beat of a burst
- mem_address  out  ADDR_W  SRAM address
- mem_read  out  1  SRAM read strobe
- mem_write  out  1  SRAM write strobe
- mem_writedata  out  DATA_W  SRAM write data
- mem_byteenable  out  DATA_W/8  SRAM byte enables
- mem_readdata  in  DATA_W  SRAM data; valid exactly 1 cycle after mem_read

## Operation
State machine with three states: IDLE, PIX_BURST, CPU_ACC.
- **IDLE.** Evaluated in this order:
  - If cpu_owed is set and (cpu_read|cpu_write) is high: go to CPU_ACC.
  - Else if pix_req is high: latch pix_addr as the base, clear the beat counter, go to PIX_BURST.
  - Else if (cpu_read|cpu_write) is high: go to CPU_ACC.
- **PIX_BURST.**
  - Each cycle: mem_read=1 and mem_address=base+count, with the address wrapping modulo 2^ADDR_W. count increments.
  - After the BURST_LEN-th issue, go to IDLE.
- **CPU_ACC.** Lasts exactly one cycle, then goes to IDLE.
  - cpu_waitrequest=0.
  - mem_address, mem_writedata and mem_byteenable pass through from the CPU port.
  - mem_read=cpu_read and mem_write=cpu_write.
  - cpu_owed is cleared.
- **cpu_waitrequest** is 1 in every state other than CPU_ACC.
- **Read return path.** A registered tag records the owner of each mem_read.
  - The cycle after a pixel read: pix_valid=1 and pix_data=mem_readdata. pix_last=1 on beat BURST_LEN-1.
  - The cycle after a CPU read: cpu_readdatavalid=1 and cpu_readdata=mem_readdata.
- **CPU write.** Produces no response.
- **cpu_read and cpu_write both high.** The write takes effect and the read is ignored; cpu_readdatavalid is not asserted.
- **Outputs with no active transaction.** The mem_* strobes are 0 outside PIX_BURST and CPU_ACC.

## Timing
- **Reset.** Reset asserted at an edge forces the following:
  - State goes to IDLE, and count and cpu_owed clear.
  - pix_ack, pix_valid, pix_last, cpu_readdatavalid, mem_read and mem_write are 0 from the next cycle.
  - cpu_waitrequest is 1.
  - cpu_readdata and pix_data are 0.
  - A burst in flight is abandoned and its pending beat is not delivered.
- **Pixel burst.** Request sampled in IDLE at cycle T:
  - pix_ack=1 in T+1 only.
  - mem_read is high in T+1..T+BURST_LEN.
  - pix_valid is high in T+2..T+BURST_LEN+1, with pix_last at T+BURST_LEN+1.
  - The state is IDLE in T+BURST_LEN+1, so a new grant can overlap the last beat.
- **Requester handshake.** The pixel requester drops pix_req no later than the cycle after pix_ack. If pix_req is still high in IDLE, it is treated as a new burst request.
- **CPU access.** Request seen in IDLE at cycle T:
  - Accepted in T+1, with cpu_waitrequest low.
  - For a read, cpu_readdatavalid in T+2.
  - Back-to-back CPU accesses take 2 cycles each.
- **CPU request hold.** The CPU holds its request signals stable while cpu_waitrequest=1, as Avalon requires.
- **Return-path conflict.** Pixel and CPU read-returns never coincide, because only one mem_read is issued per cycle.

## Configuration
- **FB_ARB_FAIRNESS_EN defined.**
  - cpu_owed is set on any PIX_BURST cycle in which (cpu_read|cpu_write) is high.
  - cpu_owed is cleared in CPU_ACC, or in IDLE when no CPU request is present.
  - Worst-case CPU acceptance latency is BURST_LEN+3 cycles from the request.
- **FB_ARB_FAIRNESS_EN undefined.**
  - cpu_owed is tied to 0, giving strict pixel priority.
  - A continuously asserted pix_req starves the CPU.

## Test plan
- **Single burst.** Reset, then pix_req=1 with pix_addr=0x0100 for one cycle (T).
  - pix_ack at T+1.
  - mem_address 0x0100..0x0107 in T+1..T+8.
  - 8 pix_valid beats of the preloaded words, with pix_last at T+9.
- **Address wrap.** Burst at pix_addr=0xFFFC: mem_address sequence is FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002, 0003.
- **CPU round trip.** CPU write 0xDEADBEEF to 0x0042 with byteenable 0xF, then a read of 0x0042: cpu_readdatavalid 2 cycles after the read request, carrying 0xDEADBEEF.
- **Contention with fairness.** pix_req held high; CPU read issued mid-burst.
  - With FB_ARB_FAIRNESS_EN: the CPU is accepted in the first IDLE after the burst, and the next burst starts 2 cycles later.
  - Without it: cpu_waitrequest stays 1 for 3 consecutive bursts.
- **Reset mid-burst.** Assert reset_reset in cycle T+4 of a burst: no pix_valid from T+5, state IDLE, and a fresh burst works normally afterwards.
- **Simultaneous requests.** pix_req and cpu_write asserted in the same IDLE cycle with cpu_owed=0: the pixel burst wins, and the CPU write is accepted at T+BURST_LEN+2.

Source files
------------

// File: rtl/fb_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fb_port_arbiter : shares one single-port frame-buffer SRAM between pixel
// refill bursts and single-word CPU accesses. Define FB_ARB_FAIRNESS_EN to
// serve a CPU request that waited through a burst before the next burst.
// Revision: 1.0
// ============================================================================
module fb_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    output logic                  cpu_waitrequest,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_readdatavalid,
    input  logic                  pix_req,
    input  logic [ADDR_W-1:0]     pix_addr,
    output logic                  pix_ack,
    output logic [DATA_W-1:0]     pix_data,
    output logic                  pix_valid,
    output logic                  pix_last,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_pix_burst = 2'd1;
    localparam logic [1:0] c_cpu_acc   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic              r_pix_tag;
    logic              r_last_tag;
    logic              r_cpu_tag;
    logic              w_cpu_req;
    logic              w_cpu_owed;
    logic              w_grant_pix;

    assign w_cpu_req   = cpu_read | cpu_write;
    assign w_grant_pix = (r_state == c_idle) && (w_next_state == c_pix_burst);

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: an owed CPU access outranks a waiting burst
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_cpu_owed && w_cpu_req) begin
                    w_next_state = c_cpu_acc;
                end else if (pix_req) begin
                    w_next_state = c_pix_burst;
                end else if (w_cpu_req) begin
                    w_next_state = c_cpu_acc;
                end
            end
            c_pix_burst: begin
                if (r_count == c_last_beat) begin
                    w_next_state = c_idle;
                end
            end
            c_cpu_acc: w_next_state = c_idle;
            default:   w_next_state = c_idle;
        endcase
    end

    // Output logic
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_writedata   = '0;
        mem_byteenable  = '0;
        cpu_waitrequest = 1'b1;
        pix_ack         = 1'b0;
        case (r_state)
            c_pix_burst: begin
                mem_read       = 1'b1;
                mem_address    = r_base + ADDR_W'(r_count);
                mem_byteenable = '1;
                pix_ack        = (r_count == '0);
            end
            c_cpu_acc: begin
                cpu_waitrequest = 1'b0;
                mem_address     = cpu_address;
                mem_writedata   = cpu_writedata;
                mem_byteenable  = cpu_byteenable;
                mem_read        = cpu_read;
                mem_write       = cpu_write;
            end
            default: ;
        endcase
    end

    // Burst bookkeeping and read-return ownership tags
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_base     <= '0;
            r_count    <= '0;
            r_pix_tag  <= 1'b0;
            r_last_tag <= 1'b0;
            r_cpu_tag  <= 1'b0;
        end else begin
            if (w_grant_pix) begin
                r_base  <= pix_addr;
                r_count <= '0;
            end else if (r_state == c_pix_burst) begin
                r_count <= r_count + 1'b1;
            end
            r_pix_tag  <= (r_state == c_pix_burst);
            r_last_tag <= (r_state == c_pix_burst) && (r_count == c_last_beat);
            // A simultaneous write wins, so its read half never returns data
            r_cpu_tag  <= (r_state == c_cpu_acc) && cpu_read && !cpu_write;
        end
    end

    assign pix_valid         = r_pix_tag;
    assign pix_last          = r_last_tag;
    assign pix_data          = r_pix_tag ? mem_readdata : '0;
    assign cpu_readdatavalid = r_cpu_tag;
    assign cpu_readdata      = r_cpu_tag ? mem_readdata : '0;

`ifdef FB_ARB_FAIRNESS_EN
    logic r_cpu_owed;

    // A CPU request that had to wait through a burst is served next
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cpu_owed <= 1'b0;
        end else begin
            case (r_state)
                c_pix_burst: if (w_cpu_req)  r_cpu_owed <= 1'b1;
                c_cpu_acc:                   r_cpu_owed <= 1'b0;
                c_idle:      if (!w_cpu_req) r_cpu_owed <= 1'b0;
                default: ;
            endcase
        end
    end

    assign w_cpu_owed = r_cpu_owed;
`else
    assign w_cpu_owed = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for fb_port_arbiter: per-cycle vector table plus
// hand-written contention and reset-mid-burst sequences.
module tb_fb_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BL = 8;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic [AW-1:0] cpu_address = '0;
    logic          cpu_read = 1'b0;
    logic          cpu_write = 1'b0;
    logic [DW-1:0] cpu_writedata = '0;
    logic [3:0]    cpu_byteenable = '0;
    logic          cpu_waitrequest;
    logic [DW-1:0] cpu_readdata;
    logic          cpu_readdatavalid;
    logic          pix_req = 1'b0;
    logic [AW-1:0] pix_addr = '0;
    logic          pix_ack;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_readdata;

    int tests = 0;
    int fails = 0;

    always #5 clk_clk = ~clk_clk;

    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
        .cpu_readdatavalid(cpu_readdatavalid),
        .pix_req(pix_req), .pix_addr(pix_addr), .pix_ack(pix_ack),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata)
    );

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a ^ 16'hC0DE, a};
    endfunction

    // SRAM model: one-cycle read latency, byte-masked writes, preloaded on reset
    logic [31:0] sram [0:65535];
    always @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < 65536; i++) sram[i] <= pat(16'(i));
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) sram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
        if (mem_read) mem_readdata <= sram[mem_address];
    end

    typedef struct {
        logic        pix_req;
        logic [15:0] pix_addr;
        logic        cpu_rd;
        logic        cpu_wr;
        logic [15:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic [3:0]  cpu_be;
        logic        e_ack;
        logic        e_mrd;
        logic        e_mwr;
        logic [15:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_pvalid;
        logic        e_plast;
        logic [31:0] e_pdata;
        logic        e_wait;
        logic        e_crdv;
        logic [31:0] e_crdata;
    } vec_t;

    function automatic vec_t idle_v();
        vec_t v;
        v = '{default: '0};
        v.e_wait = 1'b1;
        return v;
    endfunction

    // Cycle k of a burst requested (for one cycle) at k=0
    function automatic vec_t burst_v(input int k, input logic [15:0] base);
        vec_t v;
        v = idle_v();
        v.pix_req  = (k == 0);
        v.pix_addr = base;
        v.e_ack    = (k == 1);
        v.e_mrd    = (k >= 1) && (k <= BL);
        v.e_maddr  = base + 16'(k - 1);
        v.e_pvalid = (k >= 2) && (k <= BL + 1);
        v.e_pdata  = pat(base + 16'(k - 2));
        v.e_plast  = (k == BL + 1);
        return v;
    endfunction

    // Cycle k of a CPU access seen in IDLE at k=0, held until accepted at k=1
    function automatic vec_t cpu_v(input int k, input logic rd, input logic wr,
                                   input logic [15:0] addr, input logic [31:0] data,
                                   input logic [3:0] be, input logic [31:0] rdata);
        vec_t v;
        v = idle_v();
        if (k < 2) begin
            v.cpu_rd = rd; v.cpu_wr = wr; v.cpu_addr = addr;
            v.cpu_wdata = data; v.cpu_be = be;
        end
        if (k == 1) begin
            v.e_wait = 1'b0; v.e_mrd = rd; v.e_mwr = wr;
            v.e_maddr = addr; v.e_mwdata = data;
        end
        if (k == 2) begin
            v.e_crdv = rd & ~wr; v.e_crdata = rdata;
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        pix_req = v.pix_req; pix_addr = v.pix_addr;
        cpu_read = v.cpu_rd; cpu_write = v.cpu_wr; cpu_address = v.cpu_addr;
        cpu_writedata = v.cpu_wdata; cpu_byteenable = v.cpu_be;
    endtask

    task automatic check_vec(input vec_t v, input string name);
        logic ok;
        ok = (pix_ack === v.e_ack) && (mem_read === v.e_mrd) && (mem_write === v.e_mwr) &&
             (pix_valid === v.e_pvalid) && (pix_last === v.e_plast) &&
             (cpu_waitrequest === v.e_wait) && (cpu_readdatavalid === v.e_crdv);
        if (v.e_mrd || v.e_mwr) ok = ok && (mem_address === v.e_maddr);
        if (v.e_mwr) ok = ok && (mem_writedata === v.e_mwdata) && (mem_byteenable === v.cpu_be);
        if (v.e_pvalid) ok = ok && (pix_data === v.e_pdata);
        if (v.e_crdv) ok = ok && (cpu_readdata === v.e_crdata);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got ack=%b rd=%b wr=%b addr=%h pv=%b pl=%b pd=%h wait=%b crdv=%b crd=%h | want ack=%b rd=%b wr=%b addr=%h pv=%b pl=%b pd=%h wait=%b crdv=%b crd=%h",
                     name, pix_ack, mem_read, mem_write, mem_address, pix_valid, pix_last, pix_data,
                     cpu_waitrequest, cpu_readdatavalid, cpu_readdata,
                     v.e_ack, v.e_mrd, v.e_mwr, v.e_maddr, v.e_pvalid, v.e_plast, v.e_pdata,
                     v.e_wait, v.e_crdv, v.e_crdata);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(posedge clk_clk); #1;
        drive(v);
        @(negedge clk_clk);
        check_vec(v, name);
    endtask

    task automatic check_reset(input string name);
        logic ok;
        ok = (pix_ack === 1'b0) && (pix_valid === 1'b0) && (pix_last === 1'b0) &&
             (cpu_readdatavalid === 1'b0) && (mem_read === 1'b0) && (mem_write === 1'b0) &&
             (cpu_waitrequest === 1'b1) && (cpu_readdata === '0) && (pix_data === '0);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got ack=%b pv=%b pl=%b crdv=%b rd=%b wr=%b wait=%b crd=%h pd=%h | want all 0, wait=1",
                     name, pix_ack, pix_valid, pix_last, cpu_readdatavalid, mem_read, mem_write,
                     cpu_waitrequest, cpu_readdata, pix_data);
        end
    endtask

    task automatic check_ctl(input string name, input int cyc, input logic e_ack,
                             input logic e_wait, input logic e_crdv, input logic [31:0] e_crd);
        logic ok;
        ok = (pix_ack === e_ack) && (cpu_waitrequest === e_wait) && (cpu_readdatavalid === e_crdv);
        if (e_crdv) ok = ok && (cpu_readdata === e_crd);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s cyc%0d: got ack=%b wait=%b crdv=%b crd=%h | want ack=%b wait=%b crdv=%b crd=%h",
                     name, cyc, pix_ack, cpu_waitrequest, cpu_readdatavalid, cpu_readdata,
                     e_ack, e_wait, e_crdv, e_crd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        for (int k = 0; k <= BL + 2; k++) tbl.push_back(burst_v(k, 16'h0100));
        for (int k = 0; k <= BL + 2; k++) tbl.push_back(burst_v(k, 16'hFFFC));
        for (int k = 0; k < 3; k++) tbl.push_back(cpu_v(k, 1'b0, 1'b1, 16'h0042, 32'hDEADBEEF, 4'hF, 32'h0));
        for (int k = 0; k < 3; k++) tbl.push_back(cpu_v(k, 1'b1, 1'b0, 16'h0042, 32'h0, 4'hF, 32'hDEADBEEF));
        for (int k = 0; k < 3; k++) tbl.push_back(cpu_v(k, 1'b1, 1'b1, 16'h0060, 32'hCAFEF00D, 4'hF, 32'h0));
        for (int k = 0; k < 3; k++) tbl.push_back(cpu_v(k, 1'b1, 1'b0, 16'h0060, 32'h0, 4'hF, 32'hCAFEF00D));
        // Pixel and CPU write in the same IDLE cycle: burst first, write at k=BL+2
        for (int k = 0; k <= BL + 3; k++) begin
            v = (k <= BL + 1) ? burst_v(k, 16'h0200) : idle_v();
            if (k <= BL + 2) begin
                v.cpu_wr = 1'b1; v.cpu_addr = 16'h0050;
                v.cpu_wdata = 32'h12345678; v.cpu_be = 4'h3;
            end
            if (k == BL + 2) begin
                v.e_wait = 1'b0; v.e_mwr = 1'b1;
                v.e_maddr = 16'h0050; v.e_mwdata = 32'h12345678;
            end
            tbl.push_back(v);
        end
        for (int k = 0; k < 3; k++) tbl.push_back(cpu_v(k, 1'b1, 1'b0, 16'h0050, 32'h0, 4'hF, 32'hC08E5678));

        drive(idle_v());
        reset_reset = 1'b1;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check_reset("reset");
        reset_reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Continuous pixel requests with a CPU read arriving mid-burst
`ifdef FB_ARB_FAIRNESS_EN
        for (int cyc = 0; cyc <= 22; cyc++) begin
            @(posedge clk_clk); #1;
            pix_req = (cyc < 14); pix_addr = 16'h0400;
            cpu_read = (cyc >= 3) && (cyc <= 10); cpu_write = 1'b0; cpu_address = 16'h0042;
            @(negedge clk_clk);
            check_ctl("fair", cyc, (cyc == 1) || (cyc == 12), cyc != 10, cyc == 11, 32'hDEADBEEF);
        end
`else
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(posedge clk_clk); #1;
            pix_req = (cyc < 30); pix_addr = 16'h0400;
            cpu_read = (cyc >= 3) && (cyc <= 37); cpu_write = 1'b0; cpu_address = 16'h0042;
            @(negedge clk_clk);
            check_ctl("starve", cyc, (cyc == 1) || (cyc == 10) || (cyc == 19) || (cyc == 28),
                      cyc != 37, cyc == 38, 32'hDEADBEEF);
        end
`endif
        step(idle_v(), "gap");
        step(idle_v(), "gap2");

        // Reset asserted in cycle 4 of a burst
        for (int k = 0; k < 4; k++) step(burst_v(k, 16'h0300), $sformatf("rb%0d", k));
        @(posedge clk_clk); #1;
        drive(burst_v(4, 16'h0300));
        reset_reset = 1'b1;
        @(negedge clk_clk);
        check_vec(burst_v(4, 16'h0300), "rb4");
        @(posedge clk_clk); #1;
        drive(idle_v());
        @(negedge clk_clk);
        check_reset("rst_mid");
        reset_reset = 1'b0;
        step(idle_v(), "post_rst");
        for (int k = 0; k <= BL + 2; k++) step(burst_v(k, 16'h0500), $sformatf("fresh%0d", k));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
